scroll_ctrl: RTL and testbench
==============================

# scroll_ctrl

Scroll sequencer that sits directly upstream of the six per-digit 3-bit-code seven-segment decoders driving HEX5..HEX0. It divides CLOCK_50 down to a scroll tick, keeps a wrapping 0..5 rotation position, and holds a writable 6-entry message of 3-bit character codes. It drives the six rotated character codes that the decoders consume. It replaces ad-hoc counter tapping with one clean, resettable tick-and-position source.

## Interface
Parameters:
- DIV, default 50000000: prescaler period in clocks (1 s at 50 MHz); legal range DIV ≥ 1.
- CW, default 26: prescaler width; must satisfy 2^CW ≥ DIV.

Ports:
- CLOCK_50  in  1  system clock; all state on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- En  in  1  1 = run prescaler and scrolling; 0 = freeze.
- Dir  in  1  0 = Pos increments; 1 = Pos decrements.
- WrEn  in  1  message write strobe, sampled each clock.
- WrAddr  in  3  message slot 0..5; values 6 and 7 are ignored.
- WrData  in  3  character code to store.
- Tick  out  1  registered one-cycle pulse per scroll step.
- Wrap  out  1  registered one-cycle pulse when Pos wraps (5→0 up, 0→5 down).
- Pos  out  3  current rotation position, 0..5.
- C5, C4, C3, C2, C1, C0  out  3 each  character code for HEX5..HEX0.

## Operation
- Prescaler cnt (CW bits):
  - En=1 and cnt≠DIV-1: cnt+1.
  - En=1 and cnt=DIV-1: cnt←0 and the step occurs.
  - En=0: cnt holds.
- Step, on the same edge as the cnt rollover:
  - Tick←1.
  - Pos←next(Pos, Dir): up is (Pos+1) mod 6; down is (Pos+5) mod 6.
  - Wrap←1 on a 5→0 or 0→5 transition, else 0.
- Non-step cycles: Tick←0, Wrap←0, Pos holds. Pos never reaches 6 or 7.
- Dir is sampled only at the step edge. Changing Dir mid-period affects only the next step.
- Message store msg[0..5], 3 bits each:
  - Reset value: msg[i]=i.
  - WrEn=1 with WrAddr≤5 writes msg[WrAddr]←WrData at the edge.
  - WrAddr 6 or 7 causes no write.
  - A write is independent of En and of a coincident step; both take effect on the same edge.
- Outputs are combinational from registers: Ck = msg[(k+Pos) mod 6], for k=0..5. The mod-6 add is done in 4-bit arithmetic, subtracting 6 when the sum is ≥6.
- With Dir=0, content shifts one digit toward HEX0 per step and re-enters at HEX5.
- DIV=1: a step occurs on every En=1 clock.
- Reset (asserted at any time, including mid-period or mid-write):
  - cnt=0, Pos=0, Tick=0, Wrap=0, msg[i]=i.
  - Outputs read C5..C0 = 5,4,3,2,1,0 immediately, without waiting for a clock.

## Timing
- After Resetn deasserts with En=1 from the first edge, the first Tick is high after the DIV-th rising edge. Subsequent Ticks are exactly DIV clocks apart while En stays 1.
- Tick, Wrap and the new Pos change on the same edge.
- C outputs reflect the new Pos, or newly written msg, in that same cycle, with zero added latency after the edge.
- Dropping En: the period pauses and resumes where it left off. Total En=1 clocks between steps is always DIV.
- Resetn deassertion is assumed synchronous to CLOCK_50 by the board-level synchronizer. The first edge after release is a normal count edge.

## Test plan
- Reset: hold Resetn=0 with En=1 and toggling WrEn → Pos=0, Tick=0, Wrap=0, C5..C0=5,4,3,2,1,0 throughout; all return to these values asynchronously when reset is re-asserted mid-run.
- Count up (DIV=4, Dir=0, En=1): Ticks after edges 4, 8, 12, … with Pos=1,2,3,4,5,0. Wrap is high only with the 6th Tick. At Pos=1: C0=1, C5=0.
- Count down (DIV=4, Dir=1 from reset): the first Tick gives Pos=5 with Wrap=1, then Pos=4. Flipping Dir mid-period to 0 makes the next step increment.
- Pause (DIV=4): drop En for 10 clocks after 2 counted edges → no Tick during the pause; Tick arrives 2 En=1 clocks after En returns.
- Writes at Pos=0:
  - WrAddr=2, WrData=7 → C2=7 after the edge.
  - WrAddr=6, WrData=7 → no C output changes.
  - A write to slot 3 on a step edge with Dir=0 → C2=7 (new data rotated) on that edge.
- DIV=1: En=1 gives Tick high every cycle and Pos cycles 1..5,0 on consecutive clocks; Wrap is high every 6th clock.

Source files
------------

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: scroll tick prescaler, wrapping 0..5 rotation position and a
// writable 6-entry message of 3-bit character codes. C5..C0 are the rotated
// codes fed to the per-digit seven-segment decoders.
module scroll_ctrl #(
    parameter int DIV = 50000000,
    parameter int CW  = 26
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       En,
    input  logic       Dir,
    input  logic       WrEn,
    input  logic [2:0] WrAddr,
    input  logic [2:0] WrData,
    output logic       Tick,
    output logic       Wrap,
    output logic [2:0] Pos,
    output logic [2:0] C5,
    output logic [2:0] C4,
    output logic [2:0] C3,
    output logic [2:0] C2,
    output logic [2:0] C1,
    output logic [2:0] C0
);

    logic [CW-1:0]   cnt;
    logic [5:0][2:0] msg;
    logic [5:0][2:0] c;
    logic            step;

    // a step happens on the En=1 edge that closes a DIV-clock period
    assign step = En && (cnt == CW'(DIV - 1));

    // prescaler: counts only while enabled so a pause resumes mid-period
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn)
            cnt <= '0;
        else if (En)
            cnt <= step ? '0 : cnt + 1'b1;
    end

    // position, Tick and Wrap all update on the step edge; Dir sampled only here
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            Pos  <= 3'd0;
            Tick <= 1'b0;
            Wrap <= 1'b0;
        end else begin
            Tick <= step;
            Wrap <= step && (Dir ? (Pos == 3'd0) : (Pos == 3'd5));
            if (step) begin
                if (Dir)
                    Pos <= (Pos == 3'd0) ? 3'd5 : Pos - 3'd1;
                else
                    Pos <= (Pos == 3'd5) ? 3'd0 : Pos + 3'd1;
            end
        end
    end

    // message store; slots 6 and 7 do not exist so those writes drop
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 6; i++)
                msg[i] <= 3'(i);
        end else if (WrEn && (WrAddr <= 3'd5)) begin
            msg[WrAddr] <= WrData;
        end
    end

    // per-digit rotation: Ck = msg[(k+Pos) mod 6], 4-bit add with one
    // conditional subtract since both operands are at most 5
    for (genvar k = 0; k < 6; k++) begin : g_rot
        logic [3:0] sum;
        logic [2:0] idx;
        assign sum  = 4'(k) + {1'b0, Pos};
        assign idx  = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
        assign c[k] = msg[idx];
    end

    assign C0 = c[0];
    assign C1 = c[1];
    assign C2 = c[2];
    assign C3 = c[3];
    assign C4 = c[4];
    assign C5 = c[5];

endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl: two instances (DIV=4 and DIV=1) share the stimulus;
// each has its own behavioural model checked every cycle, plus directed
// literal expectations from the test plan.
module tb_scroll_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       En = 1'b0, Dir = 1'b0, WrEn = 1'b0;
    logic [2:0] WrAddr = 3'd0, WrData = 3'd0;

    logic [1:0]            tick, wrap;
    logic [1:0][2:0]       pos;
    logic [1:0][5:0][2:0]  cc;

    int errs   = 0;
    int checks = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : 1;

        scroll_ctrl #(.DIV(D), .CW((g == 0) ? 3 : 1)) dut (
            .CLOCK_50(CLOCK_50), .Resetn(Resetn), .En(En), .Dir(Dir),
            .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
            .Tick(tick[g]), .Wrap(wrap[g]), .Pos(pos[g]),
            .C5(cc[g][5]), .C4(cc[g][4]), .C3(cc[g][3]),
            .C2(cc[g][2]), .C1(cc[g][1]), .C0(cc[g][0])
        );

        // model: enabled clocks modulo DIV, position as plain mod-6 arithmetic
        int ecnt  = 0;
        int mpos  = 0;
        bit mtick = 0;
        bit mwrap = 0;
        int mmsg [6] = '{0, 1, 2, 3, 4, 5};

        always @(posedge CLOCK_50 or negedge Resetn) begin
            if (!Resetn) begin
                ecnt  <= 0;
                mpos  <= 0;
                mtick <= 0;
                mwrap <= 0;
                for (int i = 0; i < 6; i++) mmsg[i] <= i;
            end else begin
                if (WrEn && WrAddr < 6) mmsg[WrAddr] <= int'(WrData);
                mtick <= 0;
                mwrap <= 0;
                if (En) begin
                    if ((ecnt + 1) % D == 0) begin
                        mtick <= 1;
                        mpos  <= (mpos + (Dir ? 5 : 1)) % 6;
                        mwrap <= Dir ? (mpos == 0) : (mpos == 5);
                    end
                    ecnt <= (ecnt + 1) % D;
                end
            end
        end

        always @(negedge CLOCK_50) begin
            chk($sformatf("m%0d_tick", g), 32'(tick[g]), 32'(mtick));
            chk($sformatf("m%0d_wrap", g), 32'(wrap[g]), 32'(mwrap));
            chk($sformatf("m%0d_pos", g), 32'(pos[g]), 32'(mpos));
            for (int k = 0; k < 6; k++)
                chk($sformatf("m%0d_C%0d", g, k), 32'(cc[g][k]), 32'(mmsg[(k + mpos) % 6]));
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    localparam logic [17:0] RST_C = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        // reset held with En=1 and write strobes toggling
        En = 1'b1; WrAddr = 3'd2; WrData = 3'd7;
        for (int i = 0; i < 4; i++) begin
            WrEn = ~WrEn;
            clk_n(1);
            chk("rst_pos", 32'(pos[0]), 0);
            chk("rst_tick", 32'(tick[0]), 0);
            chk("rst_c", 32'(cc[0]), 32'(RST_C));
        end
        WrEn = 1'b0;
        Resetn = 1'b1;

        // count up, DIV=4: first Tick after the 4th edge
        clk_n(3);
        chk("up_notick3", 32'(tick[0]), 0);
        clk_n(1);
        chk("up_tick4", 32'(tick[0]), 1);
        chk("up_pos1", 32'(pos[0]), 1);
        chk("up_c0", 32'(cc[0][0]), 1);
        chk("up_c5", 32'(cc[0][5]), 0);
        chk("up_div1_pos", 32'(pos[1]), 4);
        clk_n(16);
        chk("up_pos5_nowrap", 32'(wrap[0]), 0);
        clk_n(4);
        chk("up_wrap6", 32'(wrap[0]), 1);
        chk("up_pos0", 32'(pos[0]), 0);

        // async reset mid-run, seen before any clock edge
        clk_n(6);
        chk("pre_rst_pos", 32'(pos[0]), 1);
        #2 Resetn = 1'b0;
        #1;
        chk("async_pos", 32'(pos[0]), 0);
        chk("async_c", 32'(cc[0]), 32'(RST_C));
        chk("async_c_div1", 32'(cc[1]), 32'(RST_C));

        // count down from reset
        Dir = 1'b1;
        @(negedge CLOCK_50);
        Resetn = 1'b1;
        clk_n(4);
        chk("dn_pos5", 32'(pos[0]), 5);
        chk("dn_wrap", 32'(wrap[0]), 1);
        clk_n(4);
        chk("dn_pos4", 32'(pos[0]), 4);
        chk("dn_nowrap", 32'(wrap[0]), 0);
        clk_n(2);
        Dir = 1'b0;
        clk_n(2);
        chk("dir_flip_pos5", 32'(pos[0]), 5);

        // pause for 10 clocks after 2 counted edges
        clk_n(2);
        En = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_n(1);
            chk("pause_notick", 32'(tick[0]), 0);
        end
        En = 1'b1;
        clk_n(1);
        chk("resume_notick", 32'(tick[0]), 0);
        clk_n(1);
        chk("resume_tick", 32'(tick[0]), 1);
        chk("resume_pos0", 32'(pos[0]), 0);

        // writes at Pos=0
        WrEn = 1'b1; WrAddr = 3'd2; WrData = 3'd7;
        clk_n(1);
        chk("wr_c2", 32'(cc[0][2]), 7);
        WrAddr = 3'd6;
        clk_n(1);
        chk("wr_addr6", 32'(cc[0]), 32'({3'd5, 3'd4, 3'd3, 3'd7, 3'd1, 3'd0}));
        WrEn = 1'b0;
        clk_n(1);
        WrEn = 1'b1; WrAddr = 3'd3; WrData = 3'd7;
        clk_n(1);
        WrEn = 1'b0;
        chk("wr_step_pos", 32'(pos[0]), 1);
        chk("wr_step_c2", 32'(cc[0][2]), 7);
        chk("wr_step_c5", 32'(cc[0][5]), 0);

        // DIV=1: step every enabled clock
        Resetn = 1'b0;
        clk_n(1);
        Resetn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            clk_n(1);
            chk("d1_tick", 32'(tick[1]), 1);
            chk("d1_pos", 32'(pos[1]), 32'(i % 6));
            chk("d1_wrap", 32'(wrap[1]), 32'(i % 6 == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
